// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift-and-adjust step per clock.
// Optional leading-zero blanking (digits above the MSD become 4'hF) under BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
  parameter int W      = 30,
  parameter int DIGITS = 10,
  parameter int CNT_W  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [W-1:0]          i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_ovf
);

  localparam int BW = 4 * DIGITS;

  // Handshake: i_start is a level sampled on every rising edge in IDLE; a sampled 1 is the
  // accepted start and captures i_bin. o_busy is high from that edge until the completing
  // edge, where o_done pulses for one cycle and o_bcd/o_ovf update together.
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     bin_q, bin_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_d, done_d, oovf_d;
  logic [BW-1:0]    obcd_d;
  logic [BW-1:0]    adj_bcd;
  logic [BW-1:0]    shift_bcd;
  logic             shift_out;

  function automatic logic [BW-1:0] adjust(input logic [BW-1:0] b);
    adjust = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) adjust[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
  endfunction

`ifdef BIN2BCD_BLANK_EN
  // Digit 0 is never blanked so a zero result still shows "0".
  function automatic logic [BW-1:0] publish(input logic [BW-1:0] b);
    logic lead;
    publish = b;
    lead    = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (b[4*i +: 4] == 4'd0)) publish[4*i +: 4] = 4'hF;
      else                               lead = 1'b0;
    end
  endfunction
`else
  function automatic logic [BW-1:0] publish(input logic [BW-1:0] b);
    publish = b;
  endfunction
`endif

  always_comb begin
    adj_bcd   = adjust(bcd_q);
    shift_bcd = {adj_bcd[BW-2:0], bin_q[W-1]};
    shift_out = adj_bcd[BW-1];

    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    busy_d  = o_busy;
    done_d  = 1'b0;
    obcd_d  = o_bcd;
    oovf_d  = o_ovf;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          bin_d   = i_bin;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(W);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bin_d = bin_q << 1;
        bcd_d = shift_bcd;
        ovf_d = ovf_q | shift_out;
        cnt_d = cnt_q - CNT_W'(1);
        // Last step: publish the result computed on this very edge.
        if (cnt_q == CNT_W'(1)) begin
          obcd_d  = publish(shift_bcd);
          oovf_d  = ovf_q | shift_out;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_bcd   <= '0;
      o_ovf   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
      o_bcd   <= obcd_d;
      o_ovf   <= oovf_d;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a 30-bit/10-digit instance and a 14-bit/4-digit instance
// exercised with directed vectors, checked by per-instance scoreboards.
module tb_bin2bcd_seq;

  localparam int W = 30, D = 10, CW = 5;
  localparam int W2 = 14, D2 = 4, CW2 = 4;
`ifdef BIN2BCD_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start_a = 1'b0, busy_a, done_a, ovf_a;
  logic [W-1:0]    bin_a = '0;
  logic [4*D-1:0]  bcd_a;
  logic            start_b = 1'b0, busy_b, done_b, ovf_b;
  logic [W2-1:0]   bin_b = '0;
  logic [4*D2-1:0] bcd_b;

  bin2bcd_seq #(.W(W), .DIGITS(D), .CNT_W(CW)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_bin(bin_a),
    .o_busy(busy_a), .o_done(done_a), .o_bcd(bcd_a), .o_ovf(ovf_a));

  bin2bcd_seq #(.W(W2), .DIGITS(D2), .CNT_W(CW2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_bin(bin_b),
    .o_busy(busy_b), .o_done(done_b), .o_bcd(bcd_b), .o_ovf(ovf_b));

  logic [4*D:0]    exp_qa[$];
  logic [4*D2:0]   exp_qb[$];
  logic [4*D:0]    mon_ea;
  logic [4*D2:0]   mon_eb;
  logic [4*D-1:0]  last_a = '0;
  int tests = 0, fails = 0, dones_a = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: pop one expected entry per o_done pulse.
  always @(negedge clk) begin
    if (rst_n && done_a) begin
      dones_a++;
      if (exp_qa.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexpected_done: got bcd %0h with empty queue at %0t", bcd_a, $time);
      end else begin
        mon_ea = exp_qa.pop_front();
        check("a_bcd", 64'(bcd_a), 64'(mon_ea[4*D-1:0]));
        check("a_ovf", 64'(ovf_a), 64'(mon_ea[4*D]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done_b) begin
      if (exp_qb.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected_done: got bcd %0h with empty queue at %0t", bcd_b, $time);
      end else begin
        mon_eb = exp_qb.pop_front();
        check("b_bcd", 64'(bcd_b), 64'(mon_eb[4*D2-1:0]));
        check("b_ovf", 64'(ovf_b), 64'(mon_eb[4*D2]));
      end
    end
  end

  task automatic run_a(input logic [W-1:0] v, input logic [4*D-1:0] plain,
                       input logic [4*D-1:0] blank, input bit second_start);
    int c, busy_n;
    logic [4*D-1:0] e;
    e = BLANK ? blank : plain;
    @(negedge clk);
    start_a = 1'b1; bin_a = v;
    exp_qa.push_back({1'b0, e});
    @(negedge clk);
    start_a = 1'b0; bin_a = W'($urandom);
    c = 0; busy_n = 0;
    while (!done_a && c < W + 5) begin
      if (busy_a) busy_n++;
      if (c == W / 2) check("a_hold", 64'(bcd_a), 64'(last_a));
      if (second_start && c == 10) begin start_a = 1'b1; bin_a = W'(999); end
      else start_a = 1'b0;
      @(negedge clk);
      c++;
    end
    start_a = 1'b0;
    check("a_latency", 64'(c), 64'(W));
    check("a_busy_cycles", 64'(busy_n), 64'(W));
    check("a_busy_end", 64'(busy_a), 64'(0));
    last_a = e;
    @(negedge clk);
    check("a_done_pulse", 64'(done_a), 64'(0));
  endtask

  task automatic run_b(input logic [W2-1:0] v, input logic [4*D2-1:0] plain,
                       input logic [4*D2-1:0] blank, input logic ovf);
    int c;
    @(negedge clk);
    start_b = 1'b1; bin_b = v;
    exp_qb.push_back({ovf, BLANK ? blank : plain});
    @(negedge clk);
    start_b = 1'b0;
    c = 0;
    while (!done_b && c < W2 + 5) begin
      @(negedge clk);
      c++;
    end
    check("b_latency", 64'(c), 64'(W2));
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0]   bv [3];
    logic [4*D-1:0] be [3];
    int c, d0;
    bv = '{W'(1000000000), W'(999), W'(5678)};
    be = '{40'h1000000000, BLANK ? 40'hFFFFFFF999 : 40'h0000000999,
           BLANK ? 40'hFFFFFF5678 : 40'h0000005678};

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_a), 64'(0));
    check("rst_done", 64'(done_a), 64'(0));
    check("rst_bcd", 64'(bcd_a), 64'(0));
    check("rst_ovf", 64'(ovf_a), 64'(0));
    check("rst_b_bcd", 64'(bcd_b), 64'(0));
    rst_n = 1'b1;

    run_a(W'(1234), 40'h0000001234, 40'hFFFFFF1234, 1'b0);
    run_a(W'(30'h3FFFFFFF), 40'h1073741823, 40'h1073741823, 1'b0);
    run_a(W'(0), 40'h0000000000, 40'hFFFFFFFFF0, 1'b0);
    run_a(W'(10), 40'h0000000010, 40'hFFFFFFFF10, 1'b0);
    run_a(W'(1234), 40'h0000001234, 40'hFFFFFF1234, 1'b1);

    // Back-to-back with i_start held high: restart on the edge right after completion.
    @(negedge clk);
    start_a = 1'b1; bin_a = bv[0];
    exp_qa.push_back({1'b0, be[0]});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("a_b2b_busy", 64'(busy_a), 64'(1));
      if (i < 2) begin bin_a = bv[i+1]; exp_qa.push_back({1'b0, be[i+1]}); end
      else start_a = 1'b0;
      c = 0;
      while (!done_a && c < W + 5) begin @(negedge clk); c++; end
      check("a_b2b_latency", 64'(c), 64'(W));
    end
    last_a = be[2];
    @(negedge clk);

    // Reset during a conversion: nothing published, outputs cleared at once.
    start_a = 1'b1; bin_a = W'(5678);
    @(negedge clk);
    start_a = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy_a), 64'(0));
    check("arst_done", 64'(done_a), 64'(0));
    check("arst_bcd", 64'(bcd_a), 64'(0));
    check("arst_ovf", 64'(ovf_a), 64'(0));
    last_a = '0;
    @(negedge clk);
    rst_n = 1'b1;
    d0 = dones_a;
    repeat (W + 10) @(negedge clk);
    check("arst_no_done", 64'(dones_a - d0), 64'(0));
    check("arst_idle", 64'(busy_a), 64'(0));

    run_b(W2'(9999), 16'h9999, 16'h9999, 1'b0);
    run_b(W2'(10000), 16'h0000, 16'hFFF0, 1'b1);
    run_b(W2'(16383), 16'h6383, 16'h6383, 1'b1);
    run_a(W'(1234), 40'h0000001234, 40'hFFFFFF1234, 1'b0);

    @(negedge clk);
    check("a_queue_empty", 64'(exp_qa.size()), 64'(0));
    check("b_queue_empty", 64'(exp_qb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
